seg7_readback: RTL and testbench

//  Receive-side decoder for the temperature-sensor display stream on io_out.
//  - Input stream: 7-segment pattern plus a decimal point. DP=0 means the tens digit is shown; DP=1 means the ones digit.
//  - The block synchronises the pins, filters out unstable patterns, and decodes each digit.
//  - It pairs a tens digit with the ones digit that follows it and emits the binary reading with a one-cycle valid strobe.
//  - Used on the companion FPGA/test harness to log readings without a camera on the LED.

---
 rtl/seg7_readback_pkg.sv | 54 +++++
 rtl/seg7_readback_seg7_to_bin.sv | 32 +++
 rtl/seg7_readback.sv | 173 +++++++++++++++++
 tb/tb_seg7_readback.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_readback_pkg.sv
// Shared 7-segment definitions for the display readback path.
// Segment patterns are {g,f,e,d,c,b,a}, bit0 = a, active-high.
package seg7_readback_pkg;

    // Digit patterns, shared with the seg7 encoder on the sensor side.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // One sample of the display pins: dp=1 means the ones digit is shown.
    typedef struct packed {
        logic       dp;
        logic [6:0] seg;
    } seg_word_t;

    // Encoder counterpart of the decoder; unknown digits show blank.
    function automatic logic [6:0] seg7_encode(input logic [3:0] digit);
        logic [6:0] pat;
        pat = SEG_BLANK;
        case (digit)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

    // tens*10+ones without a multiplier; 99 fits in 7 bits.
    function automatic logic [6:0] pair_to_bin(input logic [3:0] tens,
                                               input logic [3:0] ones);
        logic [6:0] t7;
        logic [6:0] o7;
        t7 = {3'b000, tens};
        o7 = {3'b000, ones};
        return (t7 << 3) + (t7 << 1) + o7;
    endfunction

endpackage

// File: rtl/seg7_readback_seg7_to_bin.sv
// seg7_to_bin: combinational 7-segment pattern to BCD digit decoder.
// Ports: i_seg pattern, i_is_ones position flag; o_digit, o_illegal.
module seg7_to_bin
    import seg7_readback_pkg::*;
(
    input  logic [6:0] i_seg,
    input  logic       i_is_ones,
    output logic [3:0] o_digit,
    output logic       o_illegal
);

    always_comb begin
        o_digit   = 4'd0;
        o_illegal = 1'b0;
        unique case (i_seg)
            SEG_0: o_digit = 4'd0;
            SEG_1: o_digit = 4'd1;
            SEG_2: o_digit = 4'd2;
            SEG_3: o_digit = 4'd3;
            SEG_4: o_digit = 4'd4;
            SEG_5: o_digit = 4'd5;
            SEG_6: o_digit = 4'd6;
            SEG_7: o_digit = 4'd7;
            SEG_8: o_digit = 4'd8;
            SEG_9: o_digit = 4'd9;
            // Leading-zero blanking only ever applies to the tens digit.
            SEG_BLANK: o_illegal = i_is_ones;
            default:   o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_readback.sv
// seg7_readback: decodes the multiplexed 7-segment temperature display
// back into a binary reading.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   i_segments, i_dp  raw display pins (asynchronous to clk)
//   o_value           tens*10+ones, held between strobes
//   o_tens, o_ones    last paired digits
//   o_valid           one-cycle strobe when a reading updates
//   o_error           one-cycle strobe on an accepted illegal pattern
//   o_busy            tens digit held, waiting for its ones digit
module seg7_readback
    import seg7_readback_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16,
    parameter int STAB_W        = $clog2(STABLE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] i_segments,
    input  logic       i_dp,
    output logic [6:0] o_value,
    output logic [3:0] o_tens,
    output logic [3:0] o_ones,
    output logic       o_valid,
    output logic       o_error,
    output logic       o_busy
);

    typedef enum logic {
        SEEK_TENS = 1'b0,
        HAVE_TENS = 1'b1
    } state_t;

    // Pin synchroniser, oldest stage at the top index.
    logic [SYNC_STAGES-1:0][7:0] sync_q;
    seg_word_t                   w;
    seg_word_t                   prev_w_q;

    logic [STAB_W-1:0] stab_ctr_q;
    logic [STAB_W-1:0] stab_ctr_d;
    logic              same;
    logic              accept;

    logic [3:0] dec_digit;
    logic       dec_illegal;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] held_q;
    logic [3:0] held_d;
    logic [6:0] value_q;
    logic [6:0] value_d;
    logic [3:0] tens_q;
    logic [3:0] tens_d;
    logic [3:0] ones_q;
    logic [3:0] ones_d;
    logic       valid_q;
    logic       valid_d;
    logic       error_q;
    logic       error_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= '0;
            prev_w_q <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], {i_dp, i_segments}};
            prev_w_q <= w;
        end
    end

    assign w = seg_word_t'(sync_q[SYNC_STAGES-1]);

    // The counter saturates, so a word held forever is accepted once;
    // any change restarts the episode.
    assign same   = (w == prev_w_q);
    assign accept = same &&
                    (stab_ctr_q == STAB_W'(STABLE_CYCLES - 1));

    always_comb begin
        stab_ctr_d = stab_ctr_q;
        if (!same) begin
            stab_ctr_d = '0;
        end else if (stab_ctr_q != STAB_W'(STABLE_CYCLES)) begin
            stab_ctr_d = stab_ctr_q + STAB_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stab_ctr_q <= '0;
        end else begin
            stab_ctr_q <= stab_ctr_d;
        end
    end

    seg7_to_bin u_dec (
        .i_seg     (w.seg),
        .i_is_ones (w.dp),
        .o_digit   (dec_digit),
        .o_illegal (dec_illegal)
    );

    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        value_d = value_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        valid_d = 1'b0;
        error_d = 1'b0;
        if (accept) begin
            unique case (state_q)
                SEEK_TENS: begin
                    // A ones word here means capture began mid-pair.
                    if (!w.dp) begin
                        if (dec_illegal) begin
                            error_d = 1'b1;
                        end else begin
                            held_d  = dec_digit;
                            state_d = HAVE_TENS;
                        end
                    end
                end
                HAVE_TENS: begin
                    if (dec_illegal) begin
                        error_d = 1'b1;
                        state_d = SEEK_TENS;
                    end else if (w.dp) begin
                        value_d = pair_to_bin(held_q, dec_digit);
                        tens_d  = held_q;
                        ones_d  = dec_digit;
                        valid_d = 1'b1;
                        state_d = SEEK_TENS;
                    end else begin
                        // A newer tens digit supersedes the held one.
                        held_d = dec_digit;
                    end
                end
                default: state_d = SEEK_TENS;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SEEK_TENS;
            held_q  <= '0;
            value_q <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            value_q <= value_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            valid_q <= valid_d;
            error_q <= error_d;
        end
    end

    assign o_value = value_q;
    assign o_tens  = tens_q;
    assign o_ones  = ones_q;
    assign o_valid = valid_q;
    assign o_error = error_q;
    assign o_busy  = (state_q == HAVE_TENS);

endmodule

// File: tb/tb_seg7_readback.sv
// Testbench for seg7_readback: digit-pair table, hand-written corner
// sequences and a randomised scoreboard run.
module tb_seg7_readback;

    localparam int SYNC   = 2;
    localparam int STABLE = 16;
    localparam int HOLD   = 40;

    localparam logic [6:0] SEG_TB [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    logic       clk;
    logic       reset;
    logic [6:0] i_segments;
    logic       i_dp;
    logic [6:0] o_value;
    logic [3:0] o_tens;
    logic [3:0] o_ones;
    logic       o_valid;
    logic       o_error;
    logic       o_busy;

    seg7_readback #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STABLE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_segments (i_segments),
        .i_dp       (i_dp),
        .o_value    (o_value),
        .o_tens     (o_tens),
        .o_ones     (o_ones),
        .o_valid    (o_valid),
        .o_error    (o_error),
        .o_busy     (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int v;
        int t;
        int o;
    } exp_t;

    typedef struct {
        logic [6:0] tseg;
        logic [6:0] oseg;
        int         nv;
        int         ne;
        int         val;
        int         tn;
        int         on;
    } vec_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   valid_cnt = 0;
    int   error_cnt = 0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic hold(input logic dp, input logic [6:0] seg,
                        input int n, input int jit);
        if (jit > 0) #(jit);
        i_dp       = dp;
        i_segments = seg;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int t, input int o);
        exp_t e;
        e.v = t * 10 + o;
        e.t = t;
        e.o = o;
        sb.push_back(e);
    endtask

    // Scoreboard: every valid strobe must match the oldest expected pair.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (o_valid) begin
                valid_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("sb_value", int'(o_value), e.v);
                    check("sb_tens", int'(o_tens), e.t);
                    check("sb_ones", int'(o_ones), e.o);
                end
            end
            if (o_error) error_cnt++;
            if (o_valid || o_error)
                check("valid_error_excl", int'(o_valid && o_error), 0);
        end
    end

    initial begin
        vec_t vecs[8];
        int   v0;
        int   e0;
        int   lows;
        int   lat;

        vecs[0] = '{7'h5B, 7'h7D, 1, 0, 26, 2, 6};
        vecs[1] = '{7'h00, 7'h6F, 1, 0, 9, 0, 9};
        vecs[2] = '{7'h3F, 7'h3F, 1, 0, 0, 0, 0};
        vecs[3] = '{7'h6F, 7'h6F, 1, 0, 99, 9, 9};
        vecs[4] = '{7'h7F, 7'h49, 0, 1, 99, 0, 0};
        vecs[5] = '{7'h49, 7'h06, 0, 1, 99, 0, 0};
        vecs[6] = '{7'h07, 7'h00, 0, 1, 99, 0, 0};
        vecs[7] = '{7'h66, 7'h5B, 1, 0, 42, 4, 2};

        // Reset with a ones digit already on the pins.
        reset      = 1'b1;
        i_dp       = 1'b1;
        i_segments = 7'h06;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_value", int'(o_value), 0);
        check("rst_tens", int'(o_tens), 0);
        check("rst_ones", int'(o_ones), 0);
        check("rst_valid", int'(o_valid), 0);
        check("rst_error", int'(o_error), 0);
        check("rst_busy", int'(o_busy), 0);

        // Mid-ones start, blank tens, then ones 9.
        hold(1'b1, 7'h06, HOLD, 0);
        check("midones_busy", int'(o_busy), 0);
        hold(1'b0, 7'h00, HOLD, 0);
        check("blank_tens_busy", int'(o_busy), 1);
        push(0, 9);
        hold(1'b1, 7'h6F, HOLD, 0);
        check("midones_nvalid", valid_cnt, 1);
        check("midones_nerror", error_cnt, 0);
        check("midones_value", int'(o_value), 9);

        // Table of tens/ones pairs.
        for (int i = 0; i < 8; i++) begin
            v0 = valid_cnt;
            e0 = error_cnt;
            if (vecs[i].nv == 1) push(vecs[i].tn, vecs[i].on);
            hold(1'b0, vecs[i].tseg, HOLD, 0);
            hold(1'b1, vecs[i].oseg, HOLD, 0);
            check($sformatf("vec%0d_nvalid", i), valid_cnt - v0, vecs[i].nv);
            check($sformatf("vec%0d_nerror", i), error_cnt - e0, vecs[i].ne);
            check($sformatf("vec%0d_value", i), int'(o_value), vecs[i].val);
            check($sformatf("vec%0d_busy", i), int'(o_busy), 0);
        end

        // A second legal tens digit replaces the held one.
        v0 = valid_cnt;
        hold(1'b0, 7'h06, HOLD, 0);
        hold(1'b0, 7'h4F, HOLD, 0);
        push(3, 7);
        hold(1'b1, 7'h07, HOLD, 0);
        check("replace_nvalid", valid_cnt - v0, 1);
        check("replace_value", int'(o_value), 37);

        // Illegal tens while waiting drops the pair.
        v0 = valid_cnt;
        e0 = error_cnt;
        hold(1'b0, 7'h06, HOLD, 0);
        check("illtens_busy_before", int'(o_busy), 1);
        hold(1'b0, 7'h49, HOLD, 0);
        check("illtens_busy_after", int'(o_busy), 0);
        check("illtens_nerror", error_cnt - e0, 1);
        hold(1'b1, 7'h07, HOLD, 0);
        check("illtens_nvalid", valid_cnt - v0, 0);
        check("illtens_value", int'(o_value), 37);

        // Ones pins flicker faster than the stability window.
        hold(1'b0, 7'h4F, HOLD, 0);
        v0   = valid_cnt;
        e0   = error_cnt;
        lows = 0;
        for (int k = 0; k < 16; k++) begin
            i_dp       = 1'b1;
            i_segments = k[0] ? 7'h6D : 7'h66;
            repeat (5) begin
                @(posedge clk);
                #1;
                if (!o_busy) lows++;
            end
        end
        check("flicker_busy_lows", lows, 0);
        check("flicker_nvalid", valid_cnt - v0, 0);
        check("flicker_nerror", error_cnt - e0, 0);
        push(3, 4);
        hold(1'b1, 7'h66, HOLD, 0);
        check("flicker_settle_value", int'(o_value), 34);

        // Latency from the ones word reaching the pins to the strobe.
        hold(1'b0, 7'h5B, HOLD, 0);
        push(2, 6);
        i_dp       = 1'b1;
        i_segments = 7'h7D;
        lat        = 0;
        for (int k = 1; k <= HOLD; k++) begin
            @(posedge clk);
            #1;
            if (o_valid && lat == 0) lat = k;
        end
        check("latency", lat, SYNC + STABLE + 1);
        check("latency_value", int'(o_value), 26);

        // Reset while a tens digit is held.
        v0 = valid_cnt;
        hold(1'b0, 7'h6F, HOLD, 0);
        check("rstmid_busy_before", int'(o_busy), 1);
        reset      = 1'b1;
        i_dp       = 1'b1;
        i_segments = 7'h6F;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rstmid_value", int'(o_value), 0);
        check("rstmid_tens", int'(o_tens), 0);
        check("rstmid_ones", int'(o_ones), 0);
        check("rstmid_busy", int'(o_busy), 0);
        hold(1'b1, 7'h6F, HOLD, 0);
        check("rstmid_nvalid", valid_cnt - v0, 0);

        // Random legal readings 00..63 with jittered pin changes.
        v0 = valid_cnt;
        e0 = error_cnt;
        for (int p = 0; p < 200; p++) begin
            int         val;
            int         t;
            int         o;
            logic [6:0] tseg;
            val  = int'($urandom_range(0, 63));
            t    = val / 10;
            o    = val % 10;
            tseg = SEG_TB[t];
            if (t == 0 && $urandom_range(0, 1) == 1) tseg = 7'h00;
            push(t, o);
            hold(1'b0, tseg, int'($urandom_range(20, 40)),
                 int'($urandom_range(0, 7)));
            hold(1'b1, SEG_TB[o], int'($urandom_range(20, 40)),
                 int'($urandom_range(0, 7)));
        end
        repeat (4) @(posedge clk);
        #1;
        check("rand_nvalid", valid_cnt - v0, 200);
        check("rand_nerror", error_cnt - e0, 0);
        check("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
